// File: rtl/egress_queue.sv
// Per-output packet FIFO sitting after the switch: buffers (data, destination)
// pairs under downstream backpressure and counts pops per destination.
module egress_queue #(
  parameter int    Depth    = 4,
  parameter int    NumDst   = 0,
  parameter type   data_t   = logic,
  parameter int    CntWidth = 16,
  parameter type   addr_t   = logic [(NumDst > 1 ? $clog2(NumDst) : 1)-1:0]
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  data_t                            data_i,
  input  addr_t                            addr_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output data_t                            data_o,
  output addr_t                            addr_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [$clog2(Depth):0]           usage_o,
  output logic [NumDst-1:0][CntWidth-1:0]  delivered_o
);

  localparam int PtrW   = $clog2(Depth);
  localparam int UsageW = PtrW + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high and flush_i is low; ready_o depends only on registered occupancy.
  data_t                            r_data [Depth];
  addr_t                            r_addr [Depth];
  logic [PtrW-1:0]                  r_wptr;
  logic [PtrW-1:0]                  r_rptr;
  logic [UsageW-1:0]                r_usage;
  logic [NumDst-1:0][CntWidth-1:0]  r_cnt;

  logic w_push;
  logic w_pop;

  assign ready_o     = (r_usage != UsageW'(Depth));
  assign valid_o     = (r_usage != '0);
  assign data_o      = r_data[r_rptr];
  assign addr_o      = r_addr[r_rptr];
  assign usage_o     = r_usage;
  assign delivered_o = r_cnt;

  assign w_push = valid_i && ready_o && !flush_i;
  assign w_pop  = valid_o && ready_i && !flush_i;

  // Payload storage carries no reset; only the bookkeeping below does.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wptr] <= data_i;
      r_addr[r_wptr] <= addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usage <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usage <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_usage <= r_usage + 1'b1;
        2'b01:   r_usage <= r_usage - 1'b1;
        default: r_usage <= r_usage;
      endcase
    end
  end

  // Saturating per-destination counters; flush leaves them untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      for (int d = 0; d < NumDst; d++) begin
        if (w_pop && (addr_o == addr_t'(d)) && (r_cnt[d] != '1)) begin
          r_cnt[d] <= r_cnt[d] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_egress_queue.sv
// Directed bench for egress_queue: two instances share stimulus, one with
// 16-bit counters and one with 4-bit counters to exercise saturation.
module tb_egress_queue;

  typedef logic [7:0] data_t;
  typedef logic [1:0] addr_t;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  data_t       data_i;
  addr_t       addr_i;
  logic        valid_i;
  logic        ready_i;

  logic        ready_o,  ready_o_s;
  data_t       data_o,   data_o_s;
  addr_t       addr_o,   addr_o_s;
  logic        valid_o,  valid_o_s;
  logic [2:0]  usage_o,  usage_o_s;
  logic [3:0][15:0] delivered;
  logic [3:0][3:0]  delivered_s;

  egress_queue #(.Depth(4), .NumDst(4), .data_t(data_t), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .data_i(data_i), .addr_i(addr_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .addr_o(addr_o),
    .valid_o(valid_o), .ready_i(ready_i), .usage_o(usage_o), .delivered_o(delivered)
  );

  egress_queue #(.Depth(4), .NumDst(4), .data_t(data_t), .CntWidth(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .data_i(data_i), .addr_i(addr_i),
    .valid_i(valid_i), .ready_o(ready_o_s), .data_o(data_o_s), .addr_o(addr_o_s),
    .valid_o(valid_o_s), .ready_i(ready_i), .usage_o(usage_o_s), .delivered_o(delivered_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [9:0] exp_q[$];
  int m_usage;
  int exp_c16[4];
  int exp_c4[4];
  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_usage = 0;
    for (int d = 0; d < 4; d++) begin
      exp_c16[d] = 0;
      exp_c4[d]  = 0;
    end
  endtask

  task automatic check_cnts(input string tag);
    for (int d = 0; d < 4; d++) begin
      check({tag, "_c16"}, 32'(delivered[d]),   32'(exp_c16[d]));
      check({tag, "_c4"},  32'(delivered_s[d]), 32'(exp_c4[d]));
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_usage"},   32'(usage_o),   32'(m_usage));
    check({tag, "_valid"},   32'(valid_o),   32'(m_usage != 0));
    check({tag, "_ready"},   32'(ready_o),   32'(m_usage != 4));
    check({tag, "_usage_s"}, 32'(usage_o_s), 32'(m_usage));
  endtask

  // One clock: check the head against the model, predict, advance, check status.
  task automatic cycle();
    logic       m_push, m_pop;
    logic [9:0] head;
    int         a;
    m_pop  = (m_usage != 0) && ready_i && !flush_i;
    m_push = valid_i && (m_usage != 4) && !flush_i;
    if (m_usage != 0) begin
      head = exp_q[0];
      check("head_data", 32'(data_o), 32'(head[7:0]));
      check("head_addr", 32'(addr_o), 32'(head[9:8]));
    end
    if (flush_i) begin
      exp_q.delete();
      m_usage = 0;
    end else begin
      if (m_pop) begin
        head = exp_q.pop_front();
        a = int'(head[9:8]);
        if (exp_c16[a] < 65535) exp_c16[a]++;
        if (exp_c4[a] < 15)     exp_c4[a]++;
        m_usage--;
      end
      if (m_push) begin
        exp_q.push_back({addr_i, data_i});
        m_usage++;
      end
    end
    @(posedge clk);
    #1;
    check_status("cyc");
  endtask

  task automatic drive(input logic v, input addr_t a, input data_t d, input logic r, input logic f);
    valid_i = v;
    addr_i  = a;
    data_i  = d;
    ready_i = r;
    flush_i = f;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    #12;
    check_status("in_reset");
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset / idle
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_cnts("idle");
    end

    // Fill / drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, addr_t'(i), data_t'(8'hA + i), 1'b0, 1'b0);
      cycle();
    end
    check("full_usage", 32'(usage_o), 32'd4);
    check("full_ready", 32'(ready_o), 32'd0);
    drive(1'b1, 2'd0, 8'hEE, 1'b0, 1'b0);
    cycle();
    check("fifth_rejected", 32'(usage_o), 32'd4);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    check("drain_a", 32'(data_o), 32'h0A);
    cycle();
    check("ready_back", 32'(ready_o), 32'd1);
    check("drain_b", 32'(data_o), 32'h0B);
    cycle();
    check("drain_c", 32'(data_o), 32'h0C);
    cycle();
    check("drain_d", 32'(data_o), 32'h0D);
    cycle();
    check("drained_valid", 32'(valid_o), 32'd0);
    check_cnts("fill_drain");
    check("fill_cnt3", 32'(delivered[3]), 32'd1);

    // Streaming: 100 packets to destination 2
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 2'd2, data_t'(i), 1'b1, 1'b0);
      cycle();
      check("stream_usage1", 32'(usage_o), 32'd1);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    cycle();
    check("stream_cnt2", 32'(delivered[2]), 32'd101);
    check("stream_cnt2_sat", 32'(delivered_s[2]), 32'd15);
    check_cnts("stream");

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addr_t'(i), data_t'(8'h50 + i), 1'b0, 1'b0);
      cycle();
    end
    check("pre_flush_usage", 32'(usage_o), 32'd3);
    drive(1'b1, 2'd3, 8'h77, 1'b1, 1'b1);
    cycle();
    check("flush_usage", 32'(usage_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_cnt0", 32'(delivered[0]), 32'd1);
    check_cnts("flush");
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    cycle();

    // Saturation: 20 packets to destination 1
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'd1, data_t'(8'h80 + i), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    cycle();
    check("sat_cnt1_c4", 32'(delivered_s[1]), 32'd15);
    check("sat_cnt1_c16", 32'(delivered[1]), 32'd21);
    check_cnts("sat");

    // Asynchronous reset while a pop is pending
    drive(1'b1, 2'd3, 8'h31, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'd0, 8'h32, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_usage", 32'(usage_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_ready", 32'(ready_o), 32'd1);
    check_cnts("arst");
    #2 rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
    end
    check_cnts("post_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
